// File: rtl/mem_burst_sequencer.sv
// Purpose : splits one client transfer into SDRAM bursts on one arbiter port, re-issuing the remainder after preemption.
// Latency : xfer_start -> port_req next cycle; beats pass through combinationally; last ack -> xfer_done next cycle.
// Backpres: request waits for port_ready; rd beats are never buffered, so the client must take every rd_valid beat.
//
// Ports:
//   i_clk, i_rst_n                  clock, async active-low reset
//   i_xfer_*                        client transfer request (start pulse, we, word address, word length)
//   o_xfer_busy / o_xfer_done       transfer in progress / one-cycle completion pulse
//   o_rd_data / o_rd_valid          read beats from the port
//   i_wr_data / o_wr_req            write beats to the port (client advances after each wr_req cycle)
//   o_preempt_cnt                   saturating count of bursts cut short by the arbiter
//   o_port_* / i_port_*             arbiter port request/burst interface
module mem_burst_sequencer #(
   parameter int unsigned MAX_BURST = 16
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_xfer_start,
   input  logic        i_xfer_we,
   input  logic [23:0] i_xfer_addr,
   input  logic [15:0] i_xfer_len,
   output logic        o_xfer_busy,
   output logic        o_xfer_done,
   output logic [15:0] o_rd_data,
   output logic        o_rd_valid,
   input  logic [15:0] i_wr_data,
   output logic        o_wr_req,
   output logic [7:0]  o_preempt_cnt,
   output logic        o_port_req,
   output logic        o_port_we,
   output logic [23:0] o_port_addr,
   output logic [31:0] o_port_wdata,
   output logic [7:0]  o_port_burst_len,
   output logic [15:0] o_port_burst_wdata,
   input  logic [15:0] i_port_burst_rdata,
   input  logic        i_port_burst_data_valid,
   input  logic        i_port_burst_wdata_req,
   input  logic        i_port_ack,
   input  logic        i_port_ready
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_REQ   = 2'd1,
      S_BURST = 2'd2,
      S_FIN   = 2'd3
   } state_t;

   localparam logic [15:0] MAX_LEN = 16'(MAX_BURST);

   state_t      r_state;
   state_t      w_state_nxt;
   logic [23:0] r_cur_addr;
   logic [15:0] r_remaining;
   logic [7:0]  r_burst_cnt;
   logic        r_we;
   logic [7:0]  r_preempt_cnt;

   logic [7:0]  w_burst_len;
   logic        w_accept;
   logic        w_beat;
   logic        w_ack;
   logic [8:0]  w_n;
   logic [15:0] w_rem_after;

   // Burst length is derived from remaining, which only changes on ack,
   // so it stays stable for the whole REQ/BURST pair the arbiter latched.
   assign w_burst_len = (r_remaining > MAX_LEN) ? MAX_LEN[7:0] : r_remaining[7:0];

   // A new transfer is accepted in IDLE and also in the FIN cycle.
   assign w_accept = i_xfer_start && ((r_state == S_IDLE) || (r_state == S_FIN));

   assign w_beat = (r_state == S_BURST) &&
                   (r_we ? i_port_burst_wdata_req : i_port_burst_data_valid);
   assign w_ack  = (r_state == S_BURST) && i_port_ack;

   // Words moved by this burst, including a beat landing in the ack cycle.
   assign w_n         = {1'b0, r_burst_cnt} + {8'd0, w_beat};
   assign w_rem_after = r_remaining - {7'd0, w_n};

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt      = r_state;
      o_port_req       = 1'b0;
      o_port_we        = 1'b0;
      o_port_addr      = 24'd0;
      o_port_burst_len = 8'd0;
      o_xfer_busy      = 1'b0;
      o_xfer_done      = 1'b0;
      o_rd_valid       = 1'b0;
      o_wr_req         = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (i_xfer_start) begin
               w_state_nxt = (i_xfer_len == 16'd0) ? S_FIN : S_REQ;
            end
         end
         S_REQ: begin
            o_port_req       = 1'b1;
            o_port_we        = r_we;
            o_port_addr      = r_cur_addr;
            o_port_burst_len = w_burst_len;
            o_xfer_busy      = 1'b1;
            if (i_port_ready) begin
               w_state_nxt = S_BURST;
            end
         end
         S_BURST: begin
            o_port_req       = 1'b1;
            o_port_we        = r_we;
            o_port_addr      = r_cur_addr;
            o_port_burst_len = w_burst_len;
            o_xfer_busy      = 1'b1;
            o_rd_valid       = i_port_burst_data_valid & ~r_we;
            o_wr_req         = i_port_burst_wdata_req & r_we;
            if (i_port_ack) begin
               w_state_nxt = (w_rem_after == 16'd0) ? S_FIN : S_REQ;
            end
         end
         S_FIN: begin
            o_xfer_done = 1'b1;
            if (i_xfer_start) begin
               w_state_nxt = (i_xfer_len == 16'd0) ? S_FIN : S_REQ;
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cur_addr    <= 24'd0;
         r_remaining   <= 16'd0;
         r_burst_cnt   <= 8'd0;
         r_we          <= 1'b0;
         r_preempt_cnt <= 8'd0;
      end else begin
         if (w_accept) begin
            r_cur_addr    <= i_xfer_addr;
            r_remaining   <= i_xfer_len;
            r_we          <= i_xfer_we;
            r_preempt_cnt <= 8'd0;
         end

         if (r_state == S_REQ) begin
            r_burst_cnt <= 8'd0;
         end else if (w_beat) begin
            r_burst_cnt <= w_n[7:0];
         end

         // On ack, advance past the words actually moved; a short burst
         // (including zero beats) leaves the rest for the next REQ.
         if (w_ack) begin
            r_cur_addr  <= r_cur_addr + {15'd0, w_n};
            r_remaining <= w_rem_after;
            if ((w_n < {1'b0, w_burst_len}) && (r_preempt_cnt != 8'hFF)) begin
               r_preempt_cnt <= r_preempt_cnt + 8'd1;
            end
         end
      end
   end

   assign o_rd_data          = i_port_burst_rdata;
   assign o_port_burst_wdata = i_wr_data;
   assign o_port_wdata       = 32'd0;
   assign o_preempt_cnt      = r_preempt_cnt;

   // A beat beyond the issued burst length would also overrun remaining.
   a_beat_within_burst : assert property (@(posedge i_clk) disable iff (!i_rst_n)
      w_beat |-> (r_burst_cnt < w_burst_len));

   a_no_beat_when_idle : assert property (@(posedge i_clk) disable iff (!i_rst_n)
      ((r_state == S_IDLE) || (r_state == S_FIN)) |->
      !(i_port_burst_data_valid || i_port_burst_wdata_req));

endmodule

// File: doc/mem_burst_sequencer.md
# mem_burst_sequencer

Splits one client transfer of arbitrary length into a series of SDRAM bursts on a single port of the 4-port memory arbiter. It re-issues the remaining words transparently after a burst is preempted by a higher-priority port. It sits between a streaming client (texture cache fill, framebuffer flush, Z tile load/store) and one arbiter port, and presents the client with a simple start/stream/done interface.

## Interface
- MAX_BURST, 16: maximum words per burst; legal range 1..255.
- clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous, active-low.
- xfer_start  in  1  pulse; latches xfer_we/addr/len when idle.
- xfer_we  in  1  1 = write transfer, 0 = read transfer.
- xfer_addr  in  24  start address, in 16-bit word units.
- xfer_len  in  16  number of 16-bit words; 0 is legal.
- xfer_busy  out  1  transfer in progress.
- xfer_done  out  1  one-cycle pulse at completion.
- rd_data  out  16  read word (= port_burst_rdata).
- rd_valid  out  1  rd_data valid this cycle.
- wr_data  in  16  write word; must be valid combinationally while wr_req=1.
- wr_req  out  1  client must advance to the next write word after this cycle.
- preempt_cnt  out  8  saturating count of preempted bursts; clears on xfer_start.
- port_req, port_we  out  1  to the arbiter port.
- port_addr  out  24  to the arbiter port.
- port_wdata  out  32  tied to 0.
- port_burst_len  out  8  to the arbiter port.
- port_burst_wdata  out  16  = wr_data.
- port_burst_rdata  in  16  from the arbiter port.
- port_burst_data_valid, port_burst_wdata_req, port_ack, port_ready  in  1  from the arbiter port.

## Operation
- Registers: cur_addr (24), remaining (16), burst_cnt (8, words moved in the current burst), we_r, preempt_cnt.
- State machine: IDLE, REQ, BURST, FIN.
- IDLE:
  - On xfer_start: latch inputs, clear preempt_cnt, set xfer_busy.
  - If len==0, go to FIN; otherwise go to REQ.
  - xfer_start while busy is ignored.
- REQ:
  - Drive port_req=1, port_we=we_r, port_addr=cur_addr, port_burst_len=min(remaining, MAX_BURST); clear burst_cnt.
  - Advance to BURST on the first cycle the port asserts ready. The arbiter latches the request on that edge.
- BURST:
  - Hold port_req and all port outputs stable.
  - Each port_burst_data_valid (read) or port_burst_wdata_req (write) increments burst_cnt.
  - Pass-through: rd_valid = port_burst_data_valid & !we_r; wr_req = port_burst_wdata_req & we_r.
- On port_ack in BURST:
  - Let n = burst_cnt plus any beat counted in the same cycle.
  - cur_addr += n (24-bit wrap); remaining -= n.
  - If n < the issued burst_len, increment preempt_cnt (saturates at 255).
  - If the new remaining==0, go to FIN; otherwise go to REQ.
  - port_req drops in the ack cycle's next state. If REQ re-asserts immediately, that is permitted.
- FIN: pulse xfer_done for one cycle, clear xfer_busy, return to IDLE.
- Reads: data is never buffered, so the client must accept every rd_valid beat.
- Preemption with n==0 (ack before any beat): re-issue the identical burst; this is not an error.

## Timing
- Reset values: port_req=0, port_we=0, port_addr=0, port_burst_len=0, xfer_busy=0, xfer_done=0, rd_valid=0, wr_req=0, preempt_cnt=0; state is IDLE.
- xfer_start edge -> port_req=1 next cycle; xfer_busy=1 the same next cycle.
- rd_valid and wr_req are combinational from the port inputs, so there is zero added latency on beats.
- Last ack edge -> xfer_done high for exactly the following cycle. xfer_busy falls together with xfer_done, and a new xfer_start is accepted in that cycle.
- Zero-length transfer: start edge -> xfer_done the next cycle; port_req never asserts.
- Reset mid-burst: outputs return to reset values asynchronously and the transfer is lost. The arbiter is expected to be reset by the same rst_n.
- Counters:
  - burst_cnt never exceeds port_burst_len.
  - remaining never underflows. Beats arriving after remaining reaches 0 are a protocol violation; assert in simulation.

## Test plan
- Read, len=40, addr=0x000100, MAX_BURST=16 -> three requests at 0x100/16, 0x110/16, 0x120/8; 40 rd_valid beats; one xfer_done; preempt_cnt=0.
- Read, len=16, port_ack after 5 beats -> second request at addr+5 with len 11; 16 total beats; preempt_cnt=1.
- Write, len=20, wr_data=incrementing pattern -> bursts 16 then 4; port_burst_wdata sequence matches the pattern exactly; wr_req count=20.
- xfer_len=0 -> no port_req; xfer_done one cycle after start; xfer_start while busy is ignored (addr unchanged).
- Ack with 0 beats -> identical re-request; addr wrap 0xFFFFF8 len 16 -> second burst at 0x000000 after 8-beat preempt.
- rst_n low mid-burst -> all outputs at reset values immediately; new transfer runs cleanly after release.
